// File: rtl/ram_bist_if.sv
// ram_bist_if: single-port RAM bus between a BIST initiator (master) and the RAM wrapper (slave)
interface ram_bist_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  modport master (output we, addr, wdata, input rdata);
  modport slave (input we, addr, wdata, output rdata);
endinterface

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: fill/read-back self-test master for a single-port RAM with latency-aligned compare.
// Defining BIST_INV_PASS_EN adds a second pass with the inverted pattern.
module ram_bist_ctrl #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] seed,
  ram_bist_if.master    ram,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW+1:0] err_cnt,
  output logic [AW-1:0] err_addr
);
  localparam int DCW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE
`ifdef BIST_INV_PASS_EN
    , WR_INV, RD_INV, DR_INV
`endif
  } state_t;
  typedef struct packed {
    logic          v;
    logic [DW-1:0] e;
    logic [AW-1:0] a;
  } exp_t;
  state_t        state, to_rd, to_dr, to_end;
  exp_t          pipe [RD_LAT+1];
  logic [AW-1:0] k;
  logic [DW-1:0] seed_q;
  logic [DCW-1:0] dcnt;
  logic          inv, wr_ph, rd_ph, dr_ph, last, miss, end_pass;
  logic [AW+1:0] err_nxt;
  function automatic logic [DW-1:0] pat(input logic [AW-1:0] i, input logic n);
    pat = seed_q + DW'(i);
    if (n) pat = ~pat;
  endfunction
`ifdef BIST_INV_PASS_EN
  assign inv    = state inside {WR_INV, RD_INV, DR_INV};
  assign wr_ph  = state inside {WRITE, WR_INV};
  assign rd_ph  = state inside {READ, RD_INV};
  assign dr_ph  = state inside {DRAIN, DR_INV};
  assign to_rd  = inv ? RD_INV : READ;
  assign to_dr  = inv ? DR_INV : DRAIN;
  assign to_end = inv ? DONE : WR_INV;
`else
  assign inv    = 1'b0;
  assign wr_ph  = state == WRITE;
  assign rd_ph  = state == READ;
  assign dr_ph  = state == DRAIN;
  assign to_rd  = READ;
  assign to_dr  = DRAIN;
  assign to_end = DONE;
`endif
  assign last     = k == '1;
  assign miss     = pipe[RD_LAT].v && ram.rdata != pipe[RD_LAT].e;
  assign err_nxt  = err_cnt + (AW+2)'(miss);
  // a pass ends on the edge that compares the last read, so pass uses err_nxt
  assign end_pass = (rd_ph && last && RD_LAT == 0) || (dr_ph && dcnt == DCW'(RD_LAT - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      ram.we    <= 1'b0;
      ram.addr  <= '0;
      ram.wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      err_addr  <= '0;
      k         <= '0;
      seed_q    <= '0;
      dcnt      <= '0;
      for (int i = 0; i <= RD_LAT; i++) pipe[i] <= '0;
    end else begin
      done      <= 1'b0;
      pipe[0].v <= 1'b0;
      for (int i = 1; i <= RD_LAT; i++) pipe[i] <= pipe[i-1];
      if (miss) begin
        err_cnt <= err_nxt;
        if (err_cnt == '0) err_addr <= pipe[RD_LAT].a;
      end
      if (state == IDLE) begin
        if (start) begin
          state     <= WRITE;
          seed_q    <= seed;
          busy      <= 1'b1;
          pass      <= 1'b0;
          err_cnt   <= '0;
          err_addr  <= '0;
          ram.we    <= 1'b1;
          ram.addr  <= '0;
          ram.wdata <= seed;
          k         <= '0;
        end
      end else if (wr_ph) begin
        if (last) begin
          state    <= to_rd;
          ram.we   <= 1'b0;
          ram.addr <= '0;
          k        <= '0;
          pipe[0]  <= '{v: 1'b1, e: pat('0, inv), a: '0};
        end else begin
          k         <= k + 1'b1;
          ram.addr  <= k + 1'b1;
          ram.wdata <= pat(k + 1'b1, inv);
        end
      end else if (rd_ph) begin
        if (!last) begin
          k        <= k + 1'b1;
          ram.addr <= k + 1'b1;
          pipe[0]  <= '{v: 1'b1, e: pat(k + 1'b1, inv), a: k + 1'b1};
        end else if (RD_LAT != 0) begin
          state <= to_dr;
          dcnt  <= '0;
        end
      end else if (dr_ph) dcnt <= dcnt + 1'b1;
      else state <= IDLE;
      if (end_pass) begin
        if (to_end == DONE) begin
          state <= DONE;
          done  <= 1'b1;
          busy  <= 1'b0;
          pass  <= err_nxt == '0;
        end else begin
          state     <= to_end;
          ram.we    <= 1'b1;
          ram.addr  <= '0;
          ram.wdata <= pat('0, 1'b1);
          k         <= '0;
        end
      end
    end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: block-RAM (RD_LAT=1) and distributed-RAM (RD_LAT=0) controllers driven side by side
module tb_ram_bist_ctrl;
  localparam int AW = 4, DW = 8, N = 16;
`ifdef BIST_INV_PASS_EN
  localparam int NP = 2;
`else
  localparam int NP = 1;
`endif
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] seed = '0, stuck = '0, fx = '0;
  logic [3:0] fa = '0;
  logic busy0, done0, pass0, busy1, done1, pass1;
  logic [5:0] ec0, ec1;
  logic [3:0] ea0, ea1;
  logic [7:0] mem0 [N];
  logic [7:0] mem1 [N];
  logic [7:0] dout0;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  ram_bist_if #(.AW(AW), .DW(DW)) ram0 ();
  ram_bist_if #(.AW(AW), .DW(DW)) ram1 ();
  ram_bist_ctrl #(.AW(AW), .DW(DW), .RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .ram(ram0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(ec0), .err_addr(ea0));
  ram_bist_ctrl #(.AW(AW), .DW(DW), .RD_LAT(0)) u1 (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .ram(ram1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(ec1), .err_addr(ea1));
  // faults: fx flips the stored word at address fa, stuck forces read bits to 0
  always @(posedge clk) begin
    if (ram0.we) mem0[ram0.addr] <= ram0.wdata ^ (ram0.addr == fa ? fx : 8'h00);
    dout0 <= mem0[ram0.addr];
    if (ram1.we) mem1[ram1.addr] <= ram1.wdata ^ (ram1.addr == fa ? fx : 8'h00);
  end
  assign ram0.rdata = dout0 & ~stuck;
  assign ram1.rdata = mem1[ram1.addr] & ~stuck;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask
  function automatic void model(input logic [7:0] s, input logic [7:0] st, input logic [3:0] a,
                                input logic [7:0] x, output int cnt, output int fad);
    cnt = 0;
    fad = 0;
    for (int p = 0; p < NP; p++)
      for (int i = 0; i < N; i++) begin
        logic [7:0] d, r;
        d = s + 8'(i);
        if (p == 1) d = ~d;
        r = (d ^ (i == int'(a) ? x : 8'h00)) & ~st;
        if (r != d) begin
          if (cnt == 0) fad = i;
          cnt++;
        end
      end
  endfunction
  task automatic run(input string nm, input logic [7:0] s, input logic [7:0] st, input logic [3:0] a,
                     input logic [7:0] x, input logic pulse10, input logic ep, input int ecnt, input int eaddr);
    int t0, t1, nd0, nd1;
    logic p0, p1;
    logic [5:0] c0, c1;
    logic [3:0] a0, a1;
    t0 = -1; t1 = -1; nd0 = 0; nd1 = 0;
    p0 = 1'bx; p1 = 1'bx; c0 = 'x; c1 = 'x; a0 = 'x; a1 = 'x;
    stuck = st; fa = a; fx = x;
    @(negedge clk);
    seed = s;
    start = 1'b1;
    for (int cy = 1; cy <= NP * (2 * N + 1) + 4; cy++) begin
      @(negedge clk);
      start = pulse10 && cy == 10;
      if (cy == 1) begin
        chk({nm, " busy after start"}, {busy0, busy1}, 2'b11);
        chk({nm, " stats cleared"}, {ec0, ec1, ea0, ea1, pass0, pass1}, 0);
      end
      if (done0) begin
        nd0++;
        if (t0 < 0) begin
          t0 = cy; p0 = pass0; c0 = ec0; a0 = ea0;
          chk({nm, " u0 busy at done"}, busy0, 0);
        end
      end
      if (done1) begin
        nd1++;
        if (t1 < 0) begin
          t1 = cy; p1 = pass1; c1 = ec1; a1 = ea1;
          chk({nm, " u1 busy at done"}, busy1, 0);
        end
      end
    end
    chk({nm, " u0 done cycle"}, t0, NP * (2 * N + 1) + 1);
    chk({nm, " u1 done cycle"}, t1, NP * 2 * N + 1);
    chk({nm, " done pulses"}, {nd0[7:0], nd1[7:0]}, 16'h0101);
    chk({nm, " u0 pass"}, p0, ep);
    chk({nm, " u1 pass"}, p1, ep);
    chk({nm, " u0 err_cnt"}, c0, ecnt);
    chk({nm, " u1 err_cnt"}, c1, ecnt);
    chk({nm, " u0 err_addr"}, a0, eaddr);
    chk({nm, " u1 err_addr"}, a1, eaddr);
    chk({nm, " pass held"}, {pass0, pass1}, {ep, ep});
  endtask
  typedef struct {
    logic [7:0] s, st, x;
    logic [3:0] a;
    logic       ep;
    int         ec, ea;
  } vec_t;
  vec_t tbl [8];
  initial begin
    int ec, ea;
    logic [7:0] rs, rst_m, rx;
    logic [3:0] ra;
    tbl[0] = '{8'h5A, 8'h00, 8'h00, 4'd0, 1'b1, 0, 0};
    tbl[1] = '{8'h00, 8'h01, 8'h00, 4'd0, 1'b0, 8 * NP, 1};
    tbl[2] = '{8'h01, 8'h00, 8'h00, 4'd0, 1'b1, 0, 0};
    tbl[3] = '{8'hF0, 8'h00, 8'h00, 4'd0, 1'b1, 0, 0};
    tbl[4] = '{8'h10, 8'h00, 8'h80, 4'd9, 1'b0, NP, 9};
    tbl[5] = '{8'h33, 8'h80, 8'h00, 4'd0, NP == 1, NP == 2 ? 16 : 0, 0};
    tbl[6] = '{8'hFF, 8'h00, 8'h00, 4'd0, 1'b1, 0, 0};
    tbl[7] = '{8'hFF, 8'h01, 8'h00, 4'd0, 1'b0, 8 * NP, 0};
    repeat (2) @(negedge clk);
    chk("reset u0", {ram0.we, ram0.addr, ram0.wdata, busy0, done0, pass0, ec0, ea0}, 0);
    chk("reset u1", {ram1.we, ram1.addr, ram1.wdata, busy1, done1, pass1, ec1, ea1}, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      run($sformatf("vec%0d", i), tbl[i].s, tbl[i].st, tbl[i].a, tbl[i].x, 1'b0, tbl[i].ep, tbl[i].ec, tbl[i].ea);
      if (i == 0) chk("mem0[3] seed 5A", mem0[3], NP == 2 ? 8'hA2 : 8'h5D);
      if (i == 3) chk("mem1[15] seed F0", mem1[15], NP == 2 ? 8'h00 : 8'hFF);
      if (i == 6) chk("mem0[0] seed FF", mem0[0], NP == 2 ? 8'h00 : 8'hFF);
    end
    run("start ignored", 8'h5A, 8'h00, 4'd0, 8'h00, 1'b1, 1'b1, 0, 0);
    stuck = '0; fx = '0;
    @(negedge clk);
    seed = 8'h77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !(ram0.we && ram0.addr == 4'd7); i++) @(negedge clk);
    chk("reached addr 7", {ram0.we, ram0.addr}, 5'h17);
    #2 rst = 1'b1;
    #1;
    chk("async abort u0", {ram0.we, busy0, ram0.addr, ec0}, 0);
    chk("async abort u1", {ram1.we, busy1, ram1.addr, ec1}, 0);
    @(negedge clk);
    rst = 1'b0;
    run("after reset", 8'h77, 8'h00, 4'd0, 8'h00, 1'b0, 1'b1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      rs = 8'($urandom);
      rst_m = $urandom_range(0, 2) == 0 ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      ra = 4'($urandom_range(0, 15));
      rx = $urandom_range(0, 2) == 0 ? 8'($urandom) : 8'h00;
      model(rs, rst_m, ra, rx, ec, ea);
      run($sformatf("rand%0d s=%0h st=%0h a=%0d x=%0h", i, rs, rst_m, ra, rx), rs, rst_m, ra, rx, 1'b0, ec == 0, ec, ea);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
